pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the MIPS datapath.

---
 rtl/pc_fetch_unit_if.sv | 66 ++++++
 rtl/pc_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: incrementer loop, decode controls, imem handshake and IF/ID payload.
// With MISALIGN_TRAP_EN defined the bundle also carries if_misalign.
interface pc_fetch_unit_if #(
  parameter int INSTR_W = 32
);
  logic [31:0]        pc_out;
  logic [31:0]        pc_inc_in;
  logic               stall;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               jump;
  logic [25:0]        jump_index;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;
  logic [31:0]        if_pc_inc;
`ifdef MISALIGN_TRAP_EN
  logic               if_misalign;
`endif

  modport master (
`ifdef MISALIGN_TRAP_EN
    output if_misalign,
`endif
    output pc_out,
    input  pc_inc_in,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_index,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc_inc
  );

  modport slave (
`ifdef MISALIGN_TRAP_EN
    input  if_misalign,
`endif
    input  pc_out,
    output pc_inc_in,
    output stall,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_index,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc_inc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer (BOOT/REQ/HOLD) feeding the IF/ID register.
// Optional macro MISALIGN_TRAP_EN: trap on misaligned redirect targets instead of masking them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INSTR_W  = 32
) (
  input logic              clk,
  input logic              rst_n,
  pc_fetch_unit_if.master  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_tgt_q, pend_tgt_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        ifpc_q, ifpc_d;
  logic [31:0]        ifpcinc_q, ifpcinc_d;

  logic               redirect;
  logic [31:0]        target_raw;
  logic [31:0]        target;
  logic               load_tgt;
  logic               trap;
  logic               req;
  logic               ack_eff;

  assign redirect   = bus.jump | bus.branch_taken;
  assign target_raw = bus.jump ? {bus.pc_inc_in[31:28], bus.jump_index, 2'b00}
                               : bus.branch_target;

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  // Keep the raw target so a faulting PC stays visible on pc_out.
  assign target = target_raw;
  assign trap   = trap_q;
  assign trap_d = trap_q | (load_tgt && (pc_d[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign bus.if_misalign = trap_q;
`else
  assign target = target_raw & ~32'h0000_0003;
  assign trap   = 1'b0;
`endif

  assign req     = (state_q == ST_REQ) && !trap;
  assign ack_eff = bus.imem_ack & req;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    ifpcinc_d  = ifpcinc_q;
    load_tgt   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (ack_eff) begin
          if (redirect || pend_q) begin
            // Returned word belongs to the wrong path: drop it and refetch.
            valid_d  = 1'b0;
            pend_d   = 1'b0;
            pc_d     = redirect ? target : pend_tgt_q;
            load_tgt = 1'b1;
          end else begin
            instr_d   = bus.imem_rdata;
            ifpc_d    = pc_q;
            ifpcinc_d = bus.pc_inc_in;
            valid_d   = 1'b1;
            if (bus.stall) begin
              state_d = ST_HOLD;
            end else begin
              pc_d = bus.pc_inc_in;
            end
          end
        end else begin
          // Fetch still outstanding: remember the newest redirect for when it lands.
          if (redirect && !trap) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
          if (!bus.stall) begin
            valid_d = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          valid_d  = 1'b0;
          pc_d     = target;
          load_tgt = 1'b1;
          state_d  = ST_REQ;
        end else if (!bus.stall) begin
          valid_d = 1'b0;
          pc_d    = bus.pc_inc_in;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ifpc_q     <= 32'h0;
      ifpcinc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      ifpcinc_q  <= ifpcinc_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;
  assign bus.if_pc_inc = ifpcinc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a fetch-stream model is checked every cycle,
// with literal expectations pinning the key addresses and flags.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] SALT   = 32'h1234_5678;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  pc_fetch_unit_if #(.INSTR_W(32)) bus ();

  pc_fetch_unit #(.RESET_PC(RST_PC), .INSTR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External incrementer and an instruction memory whose word is derived from its address.
  assign bus.pc_inc_in  = bus.pc_out + 32'd4;
  assign bus.imem_rdata = bus.imem_addr ^ SALT;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Model of the fetch stream: phase 0 boot, 1 fetching, 2 holding a captured word.
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifpcinc;
  logic        m_trap;

  task automatic m_reset();
    m_phase = 0; m_pc = RST_PC; m_pend = 0; m_pend_tgt = 0;
    m_valid = 0; m_instr = 0; m_ifpc = 0; m_ifpcinc = 0; m_trap = 0;
  endtask

  function automatic logic [31:0] fix_tgt(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic m_load(input logic [31:0] t);
    m_pc = t;
    if (t[1:0] != 2'b00) m_trap = 1;
  endtask

  task automatic m_step(input logic ack, input logic st, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [25:0] ji);
    logic        redir;
    logic [31:0] seq;
    logic [31:0] tgt;
    redir = jp | br;
    seq   = m_pc + 32'd4;
    tgt   = fix_tgt(jp ? {seq[31:28], ji, 2'b00} : bt);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (ack && !m_trap) begin
        if (redir || m_pend) begin
          m_valid = 0;
          m_load(redir ? tgt : m_pend_tgt);
          m_pend = 0;
        end else begin
          m_valid = 1; m_instr = m_pc ^ SALT; m_ifpc = m_pc; m_ifpcinc = seq;
          if (st) m_phase = 2;
          else    m_pc = seq;
        end
      end else begin
        if (redir && !m_trap) begin m_pend = 1; m_pend_tgt = tgt; end
        if (!st) m_valid = 0;
      end
    end else begin
      if (redir) begin
        m_valid = 0; m_load(tgt); m_phase = 1;
      end else if (!st) begin
        m_valid = 0; m_pc = seq; m_phase = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    logic exp_req;
    exp_req = (m_phase == 1) && !m_trap;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    chk("pc_out", bus.pc_out, m_pc);
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_instr", bus.if_instr, m_instr);
      chk("if_pc", bus.if_pc, m_ifpc);
      chk("if_pc_inc", bus.if_pc_inc, m_ifpcinc);
    end
`ifdef MISALIGN_TRAP_EN
    chk("if_misalign", {31'b0, bus.if_misalign}, {31'b0, m_trap});
`endif
  endtask

  task automatic tick(input logic ack, input logic st, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [25:0] ji);
    bus.imem_ack = ack; bus.stall = st; bus.branch_taken = br;
    bus.branch_target = bt; bus.jump = jp; bus.jump_index = ji;
    m_step(ack, st, br, bt, jp, ji);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d ack=%b stall=%b br=%b jmp=%b -> req=%b addr=%h valid=%b if_pc=%h",
             cyc, ack, st, br, jp, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc);
    compare_all();
  endtask

  task automatic plain(input logic ack, input logic st);
    tick(ack, st, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic branch(input logic ack, input logic st, input logic [31:0] bt);
    tick(ack, st, 1'b1, bt, 1'b0, 26'h0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    bus.imem_ack = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.branch_target = 0; bus.jump = 0; bus.jump_index = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0040_0000);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    rst_n = 1'b1;

    // Back-to-back fetches with ack tied high
    plain(1, 0);
    chk("boot_addr", bus.imem_addr, 32'h0040_0000);
    chk("boot_valid", {31'b0, bus.if_valid}, 32'h0);
    plain(1, 0);
    chk("first_valid", {31'b0, bus.if_valid}, 32'h1);
    chk("first_if_pc", bus.if_pc, 32'h0040_0000);
    chk("first_if_pc_inc", bus.if_pc_inc, 32'h0040_0004);
    plain(1, 0);
    chk("third_addr", bus.imem_addr, 32'h0040_0008);

    // Stall on the ack of 0040_0008 for three cycles
    plain(1, 1);
    chk("hold_if_pc", bus.if_pc, 32'h0040_0008);
    chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
    plain(1, 1);
    plain(1, 1);
    chk("hold_valid", {31'b0, bus.if_valid}, 32'h1);
    plain(1, 0);
    chk("after_hold_addr", bus.imem_addr, 32'h0040_000C);

    // Branch while the fetch is outstanding
    branch(0, 0, 32'h0040_0100);
    chk("pend_addr", bus.imem_addr, 32'h0040_000C);
    plain(0, 0);
    plain(0, 0);
    plain(1, 0);
    chk("drop_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("drop_addr", bus.imem_addr, 32'h0040_0100);

    // Jump beats branch
    branch(1, 0, 32'h0040_000C);
    chk("redir_addr", bus.imem_addr, 32'h0040_000C);
    tick(1, 0, 1'b1, 32'h0040_0200, 1'b1, 26'h000_0040);
    chk("jump_addr", bus.imem_addr, 32'h0000_0100);

    // Stall with no ack keeps outputs, release drops valid
    plain(1, 0);
    plain(0, 1);
    chk("stall_noack_valid", {31'b0, bus.if_valid}, 32'h1);
    chk("stall_noack_if_pc", bus.if_pc, 32'h0000_0100);
    plain(0, 0);
    chk("noack_valid", {31'b0, bus.if_valid}, 32'h0);

    // Redirect beats stall in HOLD
    plain(1, 1);
    branch(0, 1, 32'h0040_0300);
    chk("hold_redir_addr", bus.imem_addr, 32'h0040_0300);
    chk("hold_redir_valid", {31'b0, bus.if_valid}, 32'h0);

    // Wrap-around of the sequential PC
    branch(1, 0, 32'hFFFF_FFFC);
    plain(1, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk("wrap_if_pc_inc", bus.if_pc_inc, 32'h0000_0000);

    // Misaligned branch target
    branch(1, 0, 32'h0040_0102);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, bus.if_misalign}, 32'h1);
    chk("mis_req", {31'b0, bus.imem_req}, 32'h0);
    chk("mis_pc", bus.pc_out, 32'h0040_0102);
`else
    chk("mis_addr", bus.imem_addr, 32'h0040_0100);
`endif

    // Async reset with an outstanding fetch
    plain(1, 0);
    plain(0, 1);
    rst_n = 1'b0;
    m_reset();
    #2;
    chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("arst_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("arst_pc", bus.pc_out, 32'h0040_0000);
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    plain(1, 0);
    chk("restart_addr", bus.imem_addr, 32'h0040_0000);
    plain(1, 0);
    chk("restart_if_pc", bus.if_pc, 32'h0040_0000);
    plain(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
